// File: rtl/val2_pipe_shifter.sv
// Two-stage barrel shifter producing the second ALU operand and shifter carry.
// Register-specified shifts are built only when VAL2_REG_SHIFT_EN is defined.
module val2_pipe_shifter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [DATA_W-1:0] val_rs,
    input  logic [11:0]       shift_operand,
    input  logic              imm,
    input  logic              mem_acc,
    input  logic              carry_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] val2,
    output logic              carry_out
);

    localparam int LW = $clog2(DATA_W);
    localparam logic [7:0] W8 = 8'(DATA_W);

    typedef enum logic [1:0] {K_PASS, K_SHIFT, K_RRX} kind_t;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_op;
    kind_t             r_s1_kind;
    logic [1:0]        r_s1_type;
    logic [7:0]        r_s1_amt;
    logic              r_s1_cin;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_val2;
    logic              r_cout;

    logic              w_s2_free;
    logic              w_s1_load;
    logic              w_s2_load;
    logic [DATA_W-1:0] w_op;
    kind_t             w_kind;
    logic [1:0]        w_type;
    logic [7:0]        w_amt;
    logic [7:0]        w_rot;
    logic              w_unused_rs;

    assign w_s2_free = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_s1_load = in_valid && in_ready;
    assign w_s2_load = r_s1_valid && w_s2_free;
    assign w_rot     = {3'b000, shift_operand[11:8], 1'b0} & (W8 - 8'd1);

`ifdef VAL2_REG_SHIFT_EN
    assign w_unused_rs = ^val_rs[DATA_W-1:8];
`else
    assign w_unused_rs = ^val_rs;
`endif

    // S1: collapse every operand form into pass / shift(type, n) / RRX
    always_comb begin
        w_op   = val_rm;
        w_kind = K_PASS;
        w_type = shift_operand[6:5];
        w_amt  = 8'd0;
        if (mem_acc) begin
            w_op = {{(DATA_W-12){shift_operand[11]}}, shift_operand};
        end else if (imm) begin
            w_op   = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
            w_type = 2'b11;
            w_amt  = w_rot;
            if (w_rot != 8'd0) w_kind = K_SHIFT;
        end else if (!shift_operand[4]) begin
            w_amt = {3'b000, shift_operand[11:7]};
            if (w_amt != 8'd0) begin
                w_kind = K_SHIFT;
            end else begin
                unique case (shift_operand[6:5])
                    2'b00:   w_kind = K_PASS;
                    2'b11:   w_kind = K_RRX;
                    default: begin
                        w_kind = K_SHIFT;
                        w_amt  = W8;
                    end
                endcase
            end
        end else begin
`ifdef VAL2_REG_SHIFT_EN
            w_amt = val_rs[7:0];
            if (w_amt != 8'd0) w_kind = K_SHIFT;
`else
            w_op = '0;
`endif
        end
    end

    logic [LW-1:0]     w_n;
    logic [LW-1:0]     w_nm1;
    logic [LW-1:0]     w_neg;
    logic              w_lt;
    logic              w_eq;
    logic              w_sign;
    logic [DATA_W-1:0] w_shl;
    logic [DATA_W-1:0] w_shr;
    logic [DATA_W-1:0] w_sar;
    logic [DATA_W-1:0] w_ror;
    logic [DATA_W-1:0] w_val2;
    logic              w_cout;

    assign w_n    = r_s1_amt[LW-1:0];
    assign w_nm1  = w_n - LW'(1);
    assign w_neg  = LW'(0) - w_n;
    assign w_lt   = r_s1_amt < W8;
    assign w_eq   = r_s1_amt == W8;
    assign w_sign = r_s1_op[DATA_W-1];
    assign w_shl  = r_s1_op << w_n;
    assign w_shr  = r_s1_op >> w_n;
    assign w_sar  = $unsigned($signed(r_s1_op) >>> w_n);
    assign w_ror  = (r_s1_op >> w_n) | (r_s1_op << w_neg);

    // S2: the ROR carry index wraps to MSB when n mod DATA_W is zero
    always_comb begin
        w_val2 = r_s1_op;
        w_cout = r_s1_cin;
        unique case (r_s1_kind)
            K_RRX: begin
                w_val2 = {r_s1_cin, r_s1_op[DATA_W-1:1]};
                w_cout = r_s1_op[0];
            end
            K_SHIFT: begin
                unique case (r_s1_type)
                    2'b00: begin
                        w_val2 = w_lt ? w_shl : '0;
                        w_cout = w_lt ? r_s1_op[w_neg] :
                                 w_eq ? r_s1_op[0] : 1'b0;
                    end
                    2'b01: begin
                        w_val2 = w_lt ? w_shr : '0;
                        w_cout = w_lt ? r_s1_op[w_nm1] :
                                 w_eq ? w_sign : 1'b0;
                    end
                    2'b10: begin
                        w_val2 = w_lt ? w_sar : {DATA_W{w_sign}};
                        w_cout = w_lt ? r_s1_op[w_nm1] : w_sign;
                    end
                    default: begin
                        w_val2 = w_ror;
                        w_cout = r_s1_op[w_nm1];
                    end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_val2      <= '0;
            r_cout      <= 1'b0;
        end else begin
            if (w_s1_load)      r_s1_valid <= 1'b1;
            else if (w_s2_load) r_s1_valid <= 1'b0;
            if (w_s2_load) begin
                r_out_valid <= 1'b1;
                r_val2      <= w_val2;
                r_cout      <= w_cout;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_load) begin
            r_s1_op   <= w_op;
            r_s1_kind <= w_kind;
            r_s1_type <= w_type;
            r_s1_amt  <= w_amt;
            r_s1_cin  <= carry_in;
        end
    end

    assign out_valid = r_out_valid;
    assign val2      = r_val2;
    assign carry_out = r_cout;

endmodule

// File: tb/tb_val2_pipe_shifter.sv
// Bench for val2_pipe_shifter: directed cases plus randomized streaming
// against an arithmetic reference model and an in-order scoreboard.
module tb_val2_pipe_shifter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, imm, mem_acc, carry_in;
    logic        out_valid, out_ready, carry_out;
    logic [31:0] val_rm, val_rs, val2;
    logic [11:0] shift_operand;

    logic        h_in_valid, h_in_ready, h_imm, h_mem, h_cin;
    logic        h_out_valid, h_out_ready, h_carry;
    logic [15:0] h_rm, h_rs, h_val2;
    logic [11:0] h_so;

    val2_pipe_shifter #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .val_rm(val_rm), .val_rs(val_rs), .shift_operand(shift_operand),
        .imm(imm), .mem_acc(mem_acc), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .val2(val2), .carry_out(carry_out)
    );

    val2_pipe_shifter #(.DATA_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .val_rm(h_rm), .val_rs(h_rs), .shift_operand(h_so),
        .imm(h_imm), .mem_acc(h_mem), .carry_in(h_cin),
        .out_valid(h_out_valid), .out_ready(h_out_ready),
        .val2(h_val2), .carry_out(h_carry)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_pop = 0;
    logic [32:0] q[$];
    bit          held = 0;
    logic [31:0] hold_v;
    logic        hold_c;
    bit          acc;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror32(input logic [31:0] x, input int r);
        return (x >> r) | (x << (32 - r));
    endfunction

    // Result = {carry, val2}, derived from the operand rules directly
    function automatic logic [32:0] model(input logic [31:0] rm,
        input logic [31:0] rs, input logic [11:0] so,
        input logic im, input logic ma, input logic ci);
        logic [31:0]        v;
        logic               c;
        logic [63:0]        t;
        logic signed [63:0] s;
        int                 n;
        int                 r;
        v = 32'h0;
        c = ci;
        if (ma) return {ci, {20{so[11]}}, so};
        if (im) begin
            r = (2 * int'(so[11:8])) % 32;
            v = ror32({24'h0, so[7:0]}, r);
            if (r != 0) c = v[31];
            return {c, v};
        end
        if (so[4]) begin
`ifdef VAL2_REG_SHIFT_EN
            n = int'(rs[7:0]);
            if (n == 0) return {ci, rm};
`else
            return {ci, 32'h0};
`endif
        end else begin
            n = int'(so[11:7]);
            if (n == 0) begin
                case (so[6:5])
                    2'd0:    return {ci, rm};
                    2'd1:    return {rm[31], 32'h0};
                    2'd2:    return {rm[31], {32{rm[31]}}};
                    default: return {rm[0], ci, rm[31:1]};
                endcase
            end
        end
        case (so[6:5])
            2'd0: begin
                t = {32'h0, rm} << n;
                v = t[31:0];
                c = t[32];
            end
            2'd1: begin
                t = {rm, 32'h0} >> n;
                v = t[63:32];
                c = t[31];
            end
            2'd2: begin
                s = {rm, 32'h0};
                s = s >>> n;
                v = s[63:32];
                c = s[31];
            end
            default: begin
                v = ror32(rm, n % 32);
                c = v[31];
            end
        endcase
        return {c, v};
    endfunction

    // One cycle: observe handshakes mid-cycle, then advance past the edge
    task automatic step(output bit accepted);
        logic [32:0] e;
        accepted = 0;
        #2;
        if (!rst) begin
            if (held) begin
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_val2", 64'(val2), 64'(hold_v));
                chk("hold_carry", 64'(carry_out), 64'(hold_c));
            end
            held   = out_valid && !out_ready;
            hold_v = val2;
            hold_c = carry_out;
            chk("in_ready", 64'(in_ready),
                64'(!(q.size() == 2 && !out_ready)));
            if (q.size() == 0) chk("idle_out_valid", 64'(out_valid), 64'(0));
            if (out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                n_pop++;
                chk("sb_val2", 64'(val2), 64'(e[31:0]));
                chk("sb_carry", 64'(carry_out), 64'(e[32]));
            end
            if (in_valid && in_ready) begin
                q.push_back(model(val_rm, val_rs, shift_operand,
                                  imm, mem_acc, carry_in));
                accepted = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_bundle();
        val_rm        = $urandom;
        val_rs        = $urandom;
        if ($urandom_range(0, 1) == 1) val_rs[7:0] = 8'($urandom_range(0, 40));
        shift_operand = 12'($urandom);
        imm           = ($urandom_range(0, 3) == 0);
        mem_acc       = ($urandom_range(0, 4) == 0);
        carry_in      = 1'($urandom);
    endtask

    task automatic drain();
        in_valid  = 0;
        out_ready = 1;
        for (int i = 0; i < 20 && q.size() > 0; i++) step(acc);
        chk("drain_empty", 64'(q.size()), 64'(0));
    endtask

    task automatic single(input string tag, input logic [31:0] rm,
        input logic [31:0] rs, input logic [11:0] so, input logic im,
        input logic ma, input logic ci, input logic [31:0] ev,
        input logic ec);
        val_rm = rm; val_rs = rs; shift_operand = so;
        imm = im; mem_acc = ma; carry_in = ci;
        in_valid = 1; out_ready = 1;
        step(acc);
        chk({tag, "_accept"}, 64'(acc), 64'(1));
        in_valid = 0;
        val_rm   = $urandom;
        carry_in = ~ci;
        chk({tag, "_lat1"}, 64'(out_valid), 64'(0));
        step(acc);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_val2"}, 64'(val2), 64'(ev));
        chk({tag, "_carry"}, 64'(carry_out), 64'(ec));
        step(acc);
    endtask

    initial begin
        int idx;
        int pops0;
        rst = 1; in_valid = 0; out_ready = 0;
        val_rm = 0; val_rs = 0; shift_operand = 0;
        imm = 0; mem_acc = 0; carry_in = 0;
        h_in_valid = 0; h_out_ready = 1; h_rm = 0; h_rs = 0;
        h_so = 0; h_imm = 0; h_mem = 0; h_cin = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_val2", 64'(val2), 64'(0));
        chk("rst_carry", 64'(carry_out), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        single("rot_imm", 32'h0, 32'h0, 12'h4FF, 1, 0, 0, 32'hFF000000, 1);
        single("rrx", 32'h3, 32'h0, 12'h060, 0, 0, 1, 32'h80000001, 1);
        single("lsr0", 32'h80000000, 32'h0, 12'h020, 0, 0, 0, 32'h0, 1);
        single("asr0", 32'h80000001, 32'h0, 12'h040, 0, 0, 0,
               32'hFFFFFFFF, 1);
        single("mem_neg", 32'h0, 32'h0, 12'hFFC, 0, 1, 0, 32'hFFFFFFFC, 0);
`ifdef VAL2_REG_SHIFT_EN
        single("lsl_rs32", 32'h1, 32'h20, 12'h010, 0, 0, 0, 32'h0, 1);
        single("lsl_rs33", 32'h1, 32'h21, 12'h010, 0, 0, 1, 32'h0, 0);
`else
        single("regsh_off", 32'h1, 32'h20, 12'h010, 0, 0, 1, 32'h0, 1);
`endif

        h_so = 12'hFFC; h_mem = 1; h_cin = 1; h_in_valid = 1;
        @(posedge clk); #1;
        h_in_valid = 0;
        chk("w16_lat1", 64'(h_out_valid), 64'(0));
        @(posedge clk); #1;
        chk("w16_valid", 64'(h_out_valid), 64'(1));
        chk("w16_val2", 64'(h_val2), 64'(16'hFFFC));
        chk("w16_carry", 64'(h_carry), 64'(1));

        idx   = 0;
        pops0 = n_pop;
        for (int c = 0; c < 14; c++) begin
            if (c == 0 || acc) rand_bundle();
            in_valid  = (idx < 4);
            out_ready = !(c >= 2 && c <= 4);
            step(acc);
            if (acc) idx++;
        end
        drain();
        chk("b2b_count", 64'(n_pop - pops0), 64'(4));

        for (int c = 0; c < 600; c++) begin
            rand_bundle();
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            step(acc);
        end
        drain();

        out_ready = 0;
        in_valid  = 1;
        rand_bundle();
        step(acc);
        rand_bundle();
        step(acc);
        chk("full_depth", 64'(q.size()), 64'(2));
        chk("full_in_ready", 64'(in_ready), 64'(0));
        rst = 1;
        step(acc);
        rst = 0; in_valid = 0; held = 0;
        q.delete();
        chk("rst2_out_valid", 64'(out_valid), 64'(0));
        chk("rst2_val2", 64'(val2), 64'(0));
        chk("rst2_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1;
        for (int c = 0; c < 3; c++) step(acc);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
